// File: rtl/calcu_host_sequencer.sv
// calcu_host_sequencer: writes operand A, operand B and opcode to a memory-mapped processor, waits, then returns its result.
module calcu_host_sequencer #(
  parameter int HOLD_CYCLES = 10,
  parameter int GAP_CYCLES = 10,
  parameter int RESULT_WAIT = 20,
  parameter logic [31:0] ADDR_A = 32'd16,
  parameter logic [31:0] ADDR_B = 32'd20,
  parameter logic [31:0] ADDR_OP = 32'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [31:0] opcode,
  output logic [31:0] EntradaCalcu,
  output logic [31:0] addressCalcu,
  output logic        writeEnableCalcu,
  input  logic [31:0] resultadoCalcu,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ready,
  output logic        busy
);
  localparam int HG = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAXP = HG > RESULT_WAIT ? HG : RESULT_WAIT;
  localparam int CW = $clog2(MAXP + 1);
  localparam logic [CW-1:0] H1 = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] G1 = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] R1 = CW'(RESULT_WAIT - 1);
  typedef enum logic [3:0] {IDLE, WR_A, GAP_A, WR_B, GAP_B, WR_OP, GAP_OP, WAIT_RES, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] b_q, op_q, addr, data;
  logic t, accept;
  assign t = cnt == '0;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = req_valid && req_ready;
  assign res_valid = state == DONE;
  assign writeEnableCalcu = !(state inside {WR_A, WR_B, WR_OP});
  assign addressCalcu = addr;
  assign EntradaCalcu = data;
  // Counter is loaded with length-1 on entry, so a state ends on the edge where it reads zero.
  always_comb begin
    state_n = state;
    cnt_n = t ? '0 : cnt - CW'(1);
    case (state)
      IDLE:     if (req_valid) begin state_n = WR_A; cnt_n = H1; end
      WR_A:     if (t) begin state_n = GAP_A; cnt_n = G1; end
      GAP_A:    if (t) begin state_n = WR_B; cnt_n = H1; end
      WR_B:     if (t) begin state_n = GAP_B; cnt_n = G1; end
      GAP_B:    if (t) begin state_n = WR_OP; cnt_n = H1; end
      WR_OP:    if (t) begin state_n = GAP_OP; cnt_n = G1; end
      GAP_OP:   if (t) begin state_n = WAIT_RES; cnt_n = R1; end
      WAIT_RES: if (t) state_n = DONE;
      DONE:     if (res_ready) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // Address/data registers only move on edges that enter a write state, so they are stable while the strobe is low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      b_q <= '0;
      op_q <= '0;
      addr <= '0;
      data <= '0;
      res_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        b_q <= opB;
        op_q <= opcode;
        addr <= ADDR_A;
        data <= opA;
      end
      if (state == GAP_A && t) begin
        addr <= ADDR_B;
        data <= b_q;
      end
      if (state == GAP_B && t) begin
        addr <= ADDR_OP;
        data <= op_q;
      end
      if (state == WAIT_RES && t) res_data <= resultadoCalcu;
    end
  end
endmodule

// File: tb/tb_calcu_host_sequencer.sv
// tb_calcu_host_sequencer: directed checks of the host write sequence, default and minimum timing.
module tb_calcu_host_sequencer;
  logic clk = 0, rst = 1;
  logic req_valid = 0, res_ready = 0, req_ready, we, res_valid, busy;
  logic [31:0] opa = 0, opb = 0, opc = 0, result = 0, din, addr, res_data;
  logic req_valid1 = 0, res_ready1 = 0, req_ready1, we1, res_valid1, busy1;
  logic [31:0] opa1 = 0, result1 = 0, din1, addr1, res_data1;
  int checks = 0, failures = 0;
  int low_cnt = 0, low_cnt1 = 0, glitch = 0, seen99 = 0;
  logic prev_we = 1;
  logic [31:0] prev_addr = 0, prev_din = 0;
  always #5 clk = ~clk;

  calcu_host_sequencer u (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(req_ready),
    .opA(opa), .opB(opb), .opcode(opc), .EntradaCalcu(din), .addressCalcu(addr),
    .writeEnableCalcu(we), .resultadoCalcu(result), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready), .busy(busy));

  calcu_host_sequencer #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .RESULT_WAIT(1)) u1 (
    .CLK(clk), .RST(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .opA(opa1), .opB(32'd4), .opcode(32'd1), .EntradaCalcu(din1), .addressCalcu(addr1),
    .writeEnableCalcu(we1), .resultadoCalcu(result1), .res_valid(res_valid1),
    .res_data(res_data1), .res_ready(res_ready1), .busy(busy1));

  always @(negedge clk) begin
    if (!we) low_cnt++;
    if (!we1) low_cnt1++;
    if (addr == 32'd16 && din == 32'd99) seen99++;
    if (!we && !prev_we && (addr != prev_addr || din != prev_din)) glitch++;
    prev_we = we;
    prev_addr = addr;
    prev_din = din;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called right after the accepting edge; walks the 80 timed cycles and stops at the first DONE cycle.
  task automatic run_seq(input logic [31:0] a, input logic [31:0] b, input logic [31:0] op, input bit inject);
    for (int p = 0; p < 80; p++) begin
      int s = p / 20;
      int w = p % 20;
      check("we", {31'd0, we}, (s < 3 && w < 10) ? 32'd0 : 32'd1);
      check("addr", addr, s == 0 ? 32'd16 : s == 1 ? 32'd20 : 32'd0);
      check("data", din, s == 0 ? a : s == 1 ? b : op);
      check("res_valid_early", {31'd0, res_valid}, 32'd0);
      req_valid = inject && p >= 20 && p < 30;
      if (req_valid) opa = 32'd99;
      step();
    end
    req_valid = 0;
    check("res_valid_latency", {31'd0, res_valid}, 32'd1);
  endtask

  initial begin
    int base, n;
    step();
    check("rst_we", {31'd0, we}, 32'd1);
    check("rst_addr", addr, 32'd0);
    check("rst_data", din, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rst = 0;
    step();
    // minimum timing instance: 3 one-cycle strobes, result after 7 edges
    base = low_cnt1;
    opa1 = 32'd3;
    result1 = 32'd9;
    req_valid1 = 1;
    step();
    req_valid1 = 0;
    check("min_wr_a_we", {31'd0, we1}, 32'd0);
    check("min_wr_a_addr", addr1, 32'd16);
    n = 0;
    while (!res_valid1 && n < 50) begin step(); n++; end
    check("min_latency", n, 32'd7);
    check("min_res_data", res_data1, 32'd9);
    check("min_low_count", low_cnt1 - base, 32'd3);
    res_ready1 = 1;
    step();
    res_ready1 = 0;
    check("min_back_idle", {31'd0, req_ready1}, 32'd1);
    // nominal with backpressure
    base = low_cnt;
    opa = 7; opb = 8; opc = 2; result = 15;
    req_valid = 1;
    step();
    req_valid = 0;
    check("nom_busy", {31'd0, busy}, 32'd1);
    check("nom_req_ready", {31'd0, req_ready}, 32'd0);
    run_seq(32'd7, 32'd8, 32'd2, 0);
    check("nom_res_data", res_data, 32'd15);
    check("nom_low_count", low_cnt - base, 32'd30);
    result = 77;
    req_valid = 1;
    opa = 99;
    for (int i = 0; i < 50; i++) begin
      step();
      check("bp_res_valid", {31'd0, res_valid}, 32'd1);
      check("bp_res_data", res_data, 32'd15);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 0;
    res_ready = 1;
    step();
    res_ready = 0;
    check("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    check("bp_idle_busy", {31'd0, busy}, 32'd0);
    check("bp_idle_valid", {31'd0, res_valid}, 32'd0);
    check("bp_res_retained", res_data, 32'd15);
    check("bp_no_writes", low_cnt - base, 32'd30);
    // busy rejection: opA=99 offered during WR_B
    base = low_cnt;
    opa = 1; opb = 2; opc = 3; result = 5;
    req_valid = 1;
    step();
    run_seq(32'd1, 32'd2, 32'd3, 1);
    check("rej_res_data", res_data, 32'd5);
    check("rej_low_count", low_cnt - base, 32'd30);
    check("rej_no_99", seen99, 32'd0);
    res_ready = 1;
    step();
    res_ready = 0;
    // reset during 5th cycle of WR_B
    opa = 4; opb = 5; opc = 6;
    req_valid = 1;
    step();
    req_valid = 0;
    for (int p = 0; p < 24; p++) step();
    check("mid_we_low", {31'd0, we}, 32'd0);
    check("mid_addr_b", addr, 32'd20);
    rst = 1;
    step();
    rst = 0;
    check("mr_we", {31'd0, we}, 32'd1);
    check("mr_addr", addr, 32'd0);
    check("mr_data", din, 32'd0);
    check("mr_req_ready", {31'd0, req_ready}, 32'd1);
    check("mr_busy", {31'd0, busy}, 32'd0);
    // fresh request after reset, res_ready tied high, then back-to-back
    opa = 11; opb = 12; opc = 1; result = 23;
    res_ready = 1;
    req_valid = 1;
    step();
    run_seq(32'd11, 32'd12, 32'd1, 0);
    check("post_rst_res_data", res_data, 32'd23);
    opa = 40;
    req_valid = 1;
    step();
    check("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
    check("b2b_idle_busy", {31'd0, busy}, 32'd0);
    step();
    req_valid = 0;
    check("b2b_wr_a_we", {31'd0, we}, 32'd0);
    check("b2b_wr_a_addr", addr, 32'd16);
    check("b2b_wr_a_data", din, 32'd40);
    check("no_glitch", glitch, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/calcu_host_sequencer.md
CALCU_HOST_SEQUENCER -- requirements
Module: calcu_host_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, 10, cycles each write strobe is held low; legal range >=1.
REQ-002 Parameter GAP_CYCLES, 10, idle cycles with strobe high after each write; legal range >=1.
REQ-003 Parameter RESULT_WAIT, 20, cycles allowed for processor compute before result sampling; legal range >=1.
REQ-004 Parameter ADDR_A, 32'd16, address of operand A.
REQ-005 Parameter ADDR_B, 32'd20, address of operand B.
REQ-006 Parameter ADDR_OP, 32'd0, address of operation code.
REQ-007 The block SHALL use one clock and a synchronous, active-high reset: CLK in, RST in.
REQ-008 Ports SHALL be, in order after CLK/RST: req_valid in 1, request present; req_ready out 1, idle and able to accept; opA in 32, operand A; opB in 32, operand B; opcode in 32, operation code.
REQ-009 Ports SHALL continue: EntradaCalcu out 32, write data to processor; addressCalcu out 32, write address; writeEnableCalcu out 1, active-low write strobe; resultadoCalcu in 32, processor result.
REQ-010 Ports SHALL end: res_valid out 1, result available; res_data out 32, captured result; res_ready in 1, consumer accepts result; busy out 1, sequence in progress.

Function
REQ-011 FSM states SHALL be IDLE, WR_A, GAP_A, WR_B, GAP_B, WR_OP, GAP_OP, WAIT_RES, DONE; one down-counter shared by all timed states.
REQ-012 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; opA, opB, opcode SHALL be latched on that edge; the FSM enters WR_A.
REQ-013 req_ready SHALL be 1 only in IDLE; req_valid outside IDLE SHALL be ignored with no side effect.
REQ-014 In WR_A/WR_B/WR_OP: writeEnableCalcu=0, addressCalcu=ADDR_A/ADDR_B/ADDR_OP, EntradaCalcu=latched opA/opB/opcode, for exactly HOLD_CYCLES cycles.
REQ-015 In GAP_x: writeEnableCalcu=1 for exactly GAP_CYCLES cycles; addressCalcu and EntradaCalcu SHALL hold the values of the preceding write state.
REQ-016 Address and data SHALL change only on the same edge writeEnableCalcu falls (never while strobe low); no glitch between states.
REQ-017 WAIT_RES SHALL last RESULT_WAIT cycles with writeEnableCalcu=1; on its final edge resultadoCalcu SHALL be captured into res_data and the FSM enters DONE.
REQ-018 Latency: with acceptance at edge k, res_valid SHALL first be 1 after edge k + 3*(HOLD_CYCLES+GAP_CYCLES) + RESULT_WAIT; defaults give k+80.
REQ-019 In DONE res_valid=1 and res_data stable until an edge with res_ready=1; that edge returns the FSM to IDLE (req_ready=1 next cycle).
REQ-020 res_ready while res_valid=0 SHALL have no effect; res_data SHALL retain its last captured value in all other states.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 A request SHALL never be accepted in the same cycle DONE is exited; minimum back-to-back spacing is one IDLE cycle.
REQ-023 Counter width SHALL cover the largest parameter; no wrap-around for any legal value.

Reset
REQ-024 RST=1 on a rising edge SHALL force IDLE regardless of state, including mid-write.
REQ-025 Reset values: writeEnableCalcu=1, addressCalcu=0, EntradaCalcu=0, res_valid=0, res_data=0, busy=0, req_ready=1 after the reset edge.
REQ-026 Reset mid-write SHALL release the strobe (writeEnableCalcu=1) on the reset edge; no partial sequence resumes after RST falls.
REQ-027 RST has priority over req_valid and res_ready on the same edge.

Verification
REQ-028 Nominal: opA=7, opB=8, opcode=2, defaults -> strobe low 10 cycles at addr 16 data 7, high 10; addr 20 data 8; addr 0 data 2; res_valid at k+80 with res_data = resultadoCalcu driven 32'd15.
REQ-029 Backpressure: res_ready held 0 for 50 cycles after res_valid -> res_valid and res_data stable, req_ready=0, second req_valid ignored; res_ready=1 -> IDLE next cycle.
REQ-030 Busy rejection: assert req_valid with opA=99 during WR_B -> no extra writes, addr 16 never carries 99.
REQ-031 Reset mid-op: RST pulsed during 5th cycle of WR_B -> next cycle writeEnableCalcu=1, addr=0, data=0, req_ready=1; new request runs full sequence from WR_A.
REQ-032 Minimum params HOLD=GAP=RESULT_WAIT=1 -> each strobe low exactly 1 cycle, res_valid at k+7; strobe low count per request = 3*HOLD_CYCLES.
REQ-033 Back-to-back requests with res_ready tied 1 -> exactly one IDLE cycle between DONE and next WR_A.
